// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bus between the core's memory stage (master) and the
//   data-memory responder (slave).
//
//   Handshake rules for both channels: a transfer happens on a rising clock
//   edge where valid and ready are both 1. Once valid is raised, the sender
//   keeps valid and its payload unchanged until that edge. Ready may be given
//   at any time and does not depend on valid.
//
//   Signals
//     req_valid  master->slave  request present
//     req_write  master->slave  1 = store, 0 = load
//     req_addr   master->slave  byte address
//     req_wdata  master->slave  store data
//     req_ready  slave->master  responder can accept a request
//     rsp_valid  slave->master  response present
//     rsp_ready  master->slave  core takes the response
//     rsp_rdata  slave->master  load data, 0 for stores and errors
//     rsp_err    slave->master  misaligned or out-of-range access
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Responder end of the processor data-memory interface. Accepts one
//   load/store request at a time, waits a fixed number of cycles, performs the
//   access on a word-addressed RAM and presents the response until the core
//   takes it. All outputs come straight from flops.
//
//   Ports
//     clk        in   system clock, rising edge
//     reset      in   synchronous, active-low reset
//     bus        slave modport of dmem_responder_if (request/response bus)
//     dbg_state  out  current FSM state (IDLE=0, WAIT=1, RESP=2)
//
//   Parameters
//     DEPTH      number of 32-bit words, power of 2, >= 2
//     LATENCY    wait cycles between accept and access, 0..15
//
//   Timing: a request accepted at edge N performs its access at edge
//   N+LATENCY, so rsp_valid is high at edge N+LATENCY+1, the first edge at
//   which the core can take the response.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic [1:0]       dbg_state
);

    // Elaboration-time parameter checks.
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 0..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of 2 and >= 2");
    end

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  LAT_W   = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Captured request
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        write_q;

    // Registered outputs
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    // FSM strobes
    logic        capture;   // take the request on this edge
    logic        access;    // perform the RAM access on this edge

    logic [31:0] mem [DEPTH];

    // With LATENCY==0 the access happens on the accept edge itself, so the
    // operands come from the bus rather than from the capture registers.
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_write;
    logic        acc_err;
    logic [AW-1:0] acc_idx;

    assign acc_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
    assign acc_write = (state_q == S_IDLE) ? bus.req_write : write_q;
    assign acc_idx   = acc_addr[AW+1:2];
    // Any address bit above the index range is an error, never an alias.
    assign acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH_W);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 0) begin
                        access  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = LAT_W;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The 1 -> 0 step is the access edge.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    access  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, capture and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            write_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q      <= bus.req_addr;
                wdata_q     <= bus.req_wdata;
                write_q     <= bus.req_write;
                req_ready_q <= 1'b0;
            end
            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= acc_err;
                rsp_rdata_q <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
            end
            if (state_q == S_RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
                rsp_rdata_q <= 32'd0;
                rsp_err_q   <= 1'b0;
                req_ready_q <= 1'b1;
            end
        end
    end

    // RAM contents survive reset; a reset on the access edge suppresses the
    // write so a store still waiting is discarded.
    always_ff @(posedge clk) begin
        if (reset && access && acc_write && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state     = state_q;

endmodule
